delay_line_loader: RTL and testbench
====================================

Name: delay_line_loader

Overview:
- Upstream initialiser for the shift-array delay-line stage.
- On a start pulse it writes every entry of the downstream array through a single write port:
  - entry 0 gets a head sentinel;
  - entries 1..DEPTH-2 get a fill word;
  - entry DEPTH-1 gets a tail sentinel.
- The write port honours downstream backpressure.
- It pulses `done` when the array is sealed, so the shift stage can begin shifting and checking sentinels.

Parameters:
- DEPTH, 10000, number of array entries; legal range DEPTH >= 2.
- WIDTH, 32, entry width in bits.
- HEAD_WORD, 32'ha5a5a5a5, value written to entry 0.
- TAIL_WORD, 32'hdeadbeef, value written to entry DEPTH-1.
- FILL_WORD, 32'h00000000, value written to entries 1..DEPTH-2.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to (re)load the array.
- wr_ready  input  1  downstream accepts the write this cycle.
- wr_en  output  1  write request; addr/data valid while high.
- wr_addr  output  $clog2(DEPTH)  entry index.
- wr_data  output  WIDTH  entry value.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the tail write transfers.
- sealed  output  1  high from done until the next accepted start or rst.
- err  output  1  one-cycle pulse when start arrives while busy.

Behaviour:
- Reset: while rst is high at a posedge, state goes to IDLE and wr_en, wr_addr, wr_data, busy, done, sealed and err all become 0.
  - Reset mid-load aborts immediately; no further writes occur.
  - sealed stays 0, because the array is partially written.
- States: IDLE, HEAD, FILL, TAIL, DONE.
- IDLE:
  - start=1 moves to HEAD.
  - busy goes high and sealed goes low on the next cycle.
- HEAD: wr_en=1, wr_addr=0, wr_data=HEAD_WORD.
  - On transfer, go to FILL if DEPTH>2, else go to TAIL.
- FILL: wr_en=1, wr_data=FILL_WORD, wr_addr counts 1..DEPTH-2.
  - Each transfer increments the address.
  - The transfer at DEPTH-2 moves to TAIL.
- TAIL: wr_en=1, wr_addr=DEPTH-1, wr_data=TAIL_WORD.
  - On transfer, go to DONE.
- DONE: done=1 and sealed=1 for exactly one cycle, busy=0, then IDLE.
  - sealed remains 1 in IDLE.
- Handshake:
  - A transfer occurs only when wr_en && wr_ready at a posedge.
  - While wr_en=1 && wr_ready=0, wr_addr and wr_data must hold stable.
  - wr_en never drops without a transfer, except on rst.
- Each address 0..DEPTH-1 is written exactly once per load, in ascending order, with no gaps or repeats.
- Latency with wr_ready tied high, start sampled at cycle 0:
  - wr_en is high on cycles 1..DEPTH;
  - done is high on cycle DEPTH+1;
  - the next start is accepted on cycle DEPTH+1 or later.
- Start while busy (HEAD/FILL/TAIL):
  - ignored, and err pulses the following cycle;
  - the load in progress is unaffected.
- Start in DONE: accepted as a new load; done still pulses that cycle.
- Address counter: width $clog2(DEPTH), never wraps; the terminal compare is against DEPTH-2 and DEPTH-1 exactly.
- DEPTH<2 is a configuration error; elaboration must fail via a static assertion.

Decomposition:
- Package delay_line_pkg holds:
  - the state enum (IDLE, HEAD, FILL, TAIL, DONE);
  - the default sentinel constants HEAD_WORD and TAIL_WORD;
  - an addr-width helper function.
- No sub-module: the FSM and address counter are small and tightly coupled, so keep them in one module.

Test Plan:
- DEPTH=10000, wr_ready=1, start at cycle 0 ->
  - 10000 writes on cycles 1..10000;
  - addr 0 = a5a5a5a5, addr 9999 = deadbeef, all others 0;
  - done pulses on cycle 10001 and sealed=1 afterwards.
- DEPTH=4, wr_ready low on every other cycle ->
  - addr/data stable during stalls;
  - sequence (0,a5a5a5a5), (1,0), (2,0), (3,deadbeef);
  - done is a single pulse.
- DEPTH=2 -> exactly two writes (0,a5a5a5a5) then (1,deadbeef), no FILL cycle, done at cycle 3.
- DEPTH=8, start pulsed again at cycle 4 -> err pulses at cycle 5; write sequence unchanged; done at cycle 9.
- DEPTH=8, rst asserted at cycle 5 -> all outputs 0 from cycle 6, sealed=0, no further writes; a new start after reset restarts from addr 0.
- Back-to-back: start asserted in the DONE cycle -> a second full load begins and sealed drops the next cycle.

Source files
------------

// File: rtl/delay_line_pkg.sv
// rtl/delay_line_pkg.sv - shared state encoding, sentinels and width helper for the delay-line loader
package delay_line_pkg;

  // Loader phases: one write phase per region of the array, plus the seal cycle.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HEAD = 3'd1,
    FILL = 3'd2,
    TAIL = 3'd3,
    DONE = 3'd4
  } state_e;

  // Default sentinels the shift stage looks for at either end of the array.
  localparam logic [31:0] HEAD_WORD = 32'ha5a5a5a5;
  localparam logic [31:0] TAIL_WORD = 32'hdeadbeef;

  // Address width for a given depth; kept at least one bit so degenerate
  // depths still elaborate far enough to reach the depth check.
  function automatic int addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/delay_line_loader.sv
// rtl/delay_line_loader.sv - writes head/fill/tail sentinels into the delay-line array, then seals it
module delay_line_loader
  import delay_line_pkg::*;
#(
  parameter int               DEPTH     = 10000,
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] HEAD_WORD = WIDTH'(delay_line_pkg::HEAD_WORD),
  parameter logic [WIDTH-1:0] TAIL_WORD = WIDTH'(delay_line_pkg::TAIL_WORD),
  parameter logic [WIDTH-1:0] FILL_WORD = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          wr_ready,
  output logic                          wr_en,
  output logic [addr_width(DEPTH)-1:0]  wr_addr,
  output logic [WIDTH-1:0]              wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          sealed,
  output logic                          err
);

  localparam int AW = addr_width(DEPTH);

  // Terminal addresses are compared exactly, so the counter never wraps.
  localparam logic [AW-1:0] ADDR_ONE       = AW'(1);
  localparam logic [AW-1:0] ADDR_FILL_LAST = AW'(DEPTH - 2);
  localparam logic [AW-1:0] ADDR_TAIL      = AW'(DEPTH - 1);

  // An array with no room for both sentinels cannot be built.
  if (DEPTH < 2) begin : g_depth_check
    $error("delay_line_loader: DEPTH must be at least 2");
  end

  state_e        state;
  logic [AW-1:0] addr;
  logic          sealed_q;
  logic          err_q;
  logic          active;

  assign active = (state == HEAD) || (state == FILL) || (state == TAIL);

  // FSM and address counter: advance one entry per accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      sealed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= start && active;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= HEAD;
            addr     <= '0;
            sealed_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        HEAD: begin
          if (wr_ready) begin
            if (DEPTH > 2) begin
              state <= FILL;
              addr  <= ADDR_ONE;
            end else begin
              state <= TAIL;
              addr  <= ADDR_TAIL;
            end
          end
        end
        FILL: begin
          if (wr_ready) begin
            if (addr == ADDR_FILL_LAST) begin
              state <= TAIL;
              addr  <= ADDR_TAIL;
            end else begin
              addr <= addr + ADDR_ONE;
            end
          end
        end
        TAIL: begin
          if (wr_ready) begin
            state    <= DONE;
            addr     <= '0;
            sealed_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write data follows the phase; idle and seal cycles present zero.
  always_comb begin
    wr_data = '0;
    case (state)
      HEAD:    wr_data = HEAD_WORD;
      FILL:    wr_data = FILL_WORD;
      TAIL:    wr_data = TAIL_WORD;
      default: wr_data = '0;
    endcase
  end

  assign wr_en   = active;
  assign wr_addr = addr;
  assign busy    = active;
  assign done    = (state == DONE);
  assign sealed  = sealed_q;
  assign err     = err_q;

endmodule

// File: tb/tb_delay_line_loader.sv
// tb/tb_delay_line_loader.sv - self-checking bench for delay_line_loader at several depths
module tb_delay_line_loader;

  localparam int NI = 4;

  function automatic int dep(input int i);
    case (i)
      0:       return 10000;
      1:       return 8;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       rst_v;
  logic [NI-1:0]       start_v;
  logic [NI-1:0]       ready_v;
  logic [NI-1:0]       en_v;
  logic [NI-1:0]       busy_v;
  logic [NI-1:0]       done_v;
  logic [NI-1:0]       sealed_v;
  logic [NI-1:0]       err_v;
  logic [NI-1:0][13:0] addr_v;
  logic [NI-1:0][31:0] data_v;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = dep(g);
    localparam int AW = $clog2(D);
    logic [AW-1:0] a;
    delay_line_loader #(.DEPTH(D)) u_dut (
      .clk      (clk),
      .rst      (rst_v[g]),
      .start    (start_v[g]),
      .wr_ready (ready_v[g]),
      .wr_en    (en_v[g]),
      .wr_addr  (a),
      .wr_data  (data_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .sealed   (sealed_v[g]),
      .err      (err_v[g])
    );
    assign addr_v[g] = 14'(a);
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int inst, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (depth %0d) got %0h expected %0h", name, dep(inst), got, exp);
    end
  endtask

  // Reference model: m_idx is the array entry due to be written next
  // (-1 when idle, DEPTH during the seal cycle).
  int m_idx   [NI];
  bit m_sealed[NI];
  bit m_err   [NI];
  bit m_zero  [NI];

  function automatic logic [31:0] word_at(input int i, input int d);
    if (i == 0)     return 32'ha5a5a5a5;
    if (i == d - 1) return 32'hdeadbeef;
    return 32'h00000000;
  endfunction

  task automatic model_check();
    for (int g = 0; g < NI; g++) begin
      int d;
      bit act;
      d   = dep(g);
      act = (m_idx[g] >= 0) && (m_idx[g] < d);
      chk("wr_en",  g, 64'(en_v[g]),     64'(act));
      chk("busy",   g, 64'(busy_v[g]),   64'(act));
      chk("done",   g, 64'(done_v[g]),   64'(m_idx[g] == d));
      chk("sealed", g, 64'(sealed_v[g]), 64'(m_sealed[g]));
      chk("err",    g, 64'(err_v[g]),    64'(m_err[g]));
      if (act) begin
        chk("wr_addr", g, 64'(addr_v[g]), 64'(m_idx[g]));
        chk("wr_data", g, 64'(data_v[g]), 64'(word_at(m_idx[g], d)));
      end
      if (m_zero[g]) begin
        chk("wr_addr_rst", g, 64'(addr_v[g]), 64'd0);
        chk("wr_data_rst", g, 64'(data_v[g]), 64'd0);
      end
    end
  endtask

  task automatic model_step();
    for (int g = 0; g < NI; g++) begin
      int d;
      bit act;
      d   = dep(g);
      act = (m_idx[g] >= 0) && (m_idx[g] < d);
      if (rst_v[g]) begin
        m_idx[g]    = -1;
        m_sealed[g] = 1'b0;
        m_err[g]    = 1'b0;
        m_zero[g]   = 1'b1;
      end else begin
        m_err[g] = start_v[g] && act;
        if (!act) begin
          if (start_v[g]) begin
            m_idx[g]    = 0;
            m_sealed[g] = 1'b0;
            m_zero[g]   = 1'b0;
          end else begin
            m_idx[g] = -1;
          end
        end else if (ready_v[g]) begin
          m_idx[g] = m_idx[g] + 1;
          if (m_idx[g] == d) m_sealed[g] = 1'b1;
        end
      end
    end
  endtask

  int sc_inst;
  int cyc;
  int ev_writes, ev_done_cyc, ev_last_done, ev_done_cnt, ev_err_cyc;

  task automatic clear_events();
    cyc          = 0;
    ev_writes    = 0;
    ev_done_cyc  = -1;
    ev_last_done = -1;
    ev_done_cnt  = 0;
    ev_err_cyc   = -1;
  endtask

  task automatic cycle();
    model_check();
    if (sc_inst >= 0) begin
      if (en_v[sc_inst] && ready_v[sc_inst] && !rst_v[sc_inst]) ev_writes++;
      if (done_v[sc_inst]) begin
        ev_done_cnt++;
        ev_last_done = cyc;
        if (ev_done_cyc < 0) ev_done_cyc = cyc;
      end
      if (err_v[sc_inst] && ev_err_cyc < 0) ev_err_cyc = cyc;
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_all();
    rst_v   = '1;
    start_v = '0;
    ready_v = '0;
    cycle();
    rst_v = '0;
  endtask

  typedef struct {
    int inst;
    bit alt_ready;
    int start2;
    int rst_at;
    int len;
    int exp_writes;
    int exp_done;
    int exp_err;
    int exp_done_cnt;
  } scen_t;

  scen_t scen[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    scen[0] = '{0, 1'b0, -1, -1, 10005, 10000, 10001, -1, 1};
    scen[1] = '{2, 1'b1, -1, -1,    12,     4,     8, -1, 1};
    scen[2] = '{3, 1'b0, -1, -1,     6,     2,     3, -1, 1};
    scen[3] = '{1, 1'b0,  4, -1,    12,     8,     9,  5, 1};
    scen[4] = '{1, 1'b0, -1,  5,    12,     4,    -1, -1, 0};

    sc_inst = -1;
    clear_events();
    rst_v   = '1;
    start_v = '0;
    ready_v = '0;
    for (int g = 0; g < NI; g++) begin
      m_idx[g] = -1; m_sealed[g] = 1'b0; m_err[g] = 1'b0; m_zero[g] = 1'b1;
    end
    @(negedge clk);
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst_v = '0;

    // Reset state, checked explicitly on one instance.
    chk("rst wr_en",   1, 64'(en_v[1]),     64'd0);
    chk("rst busy",    1, 64'(busy_v[1]),   64'd0);
    chk("rst done",    1, 64'(done_v[1]),   64'd0);
    chk("rst sealed",  1, 64'(sealed_v[1]), 64'd0);
    chk("rst err",     1, 64'(err_v[1]),    64'd0);
    chk("rst wr_addr", 1, 64'(addr_v[1]),   64'd0);
    chk("rst wr_data", 1, 64'(data_v[1]),   64'd0);

    // Table-driven scenarios.
    for (int s = 0; s < 5; s++) begin
      int gi;
      gi = scen[s].inst;
      sc_inst = -1;
      reset_all();
      sc_inst = gi;
      clear_events();
      for (int c = 0; c < scen[s].len; c++) begin
        start_v[gi] = (c == 0) || (c == scen[s].start2);
        ready_v[gi] = scen[s].alt_ready ? c[0] : 1'b1;
        rst_v[gi]   = (c == scen[s].rst_at);
        cycle();
      end
      start_v = '0;
      ready_v = '0;
      rst_v   = '0;
      chk("scen writes",    gi, 64'(ev_writes),   64'(scen[s].exp_writes));
      chk("scen done cyc",  gi, 64'(ev_done_cyc), 64'(scen[s].exp_done));
      chk("scen done cnt",  gi, 64'(ev_done_cnt), 64'(scen[s].exp_done_cnt));
      chk("scen err cyc",   gi, 64'(ev_err_cyc),  64'(scen[s].exp_err));
      chk("scen sealed",    gi, 64'(sealed_v[gi]), 64'(scen[s].exp_done_cnt > 0));
    end

    // After the mid-load reset: a fresh start restarts from entry 0.
    start_v[1] = 1'b1;
    ready_v[1] = 1'b1;
    cycle();
    start_v[1] = 1'b0;
    chk("restart wr_en",   1, 64'(en_v[1]),     64'd1);
    chk("restart wr_addr", 1, 64'(addr_v[1]),   64'd0);
    chk("restart wr_data", 1, 64'(data_v[1]),   64'ha5a5a5a5);
    chk("restart sealed",  1, 64'(sealed_v[1]), 64'd0);
    for (int c = 0; c < 10; c++) cycle();
    chk("restart sealed end", 1, 64'(sealed_v[1]), 64'd1);
    ready_v[1] = 1'b0;

    // Back-to-back: start during the seal cycle begins a second load.
    sc_inst = -1;
    reset_all();
    sc_inst = 2;
    clear_events();
    for (int c = 0; c < 16; c++) begin
      start_v[2] = (c == 0) || (c == 5);
      ready_v[2] = 1'b1;
      if (c == 5) begin
        chk("b2b done",   2, 64'(done_v[2]),   64'd1);
        chk("b2b sealed", 2, 64'(sealed_v[2]), 64'd1);
      end
      if (c == 6) begin
        chk("b2b sealed drop", 2, 64'(sealed_v[2]), 64'd0);
        chk("b2b busy",        2, 64'(busy_v[2]),   64'd1);
        chk("b2b wr_addr",     2, 64'(addr_v[2]),   64'd0);
      end
      cycle();
    end
    start_v = '0;
    ready_v = '0;
    chk("b2b done cnt",   2, 64'(ev_done_cnt),  64'd2);
    chk("b2b last done",  2, 64'(ev_last_done), 64'd10);
    chk("b2b writes",     2, 64'(ev_writes),    64'd8);

    // Randomized traffic on every instance against the model.
    sc_inst = -1;
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < NI; g++) begin
        start_v[g] = ($urandom_range(0, 19) == 0);
        ready_v[g] = ($urandom_range(0, 2) != 0);
        rst_v[g]   = ($urandom_range(0, 499) == 0);
      end
      cycle();
    end
    start_v = '0;
    ready_v = '0;
    rst_v   = '0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
